// File: rtl/dpram_pkg.sv
// Shared types and elaboration helpers for the parametrised dual-port RAM.
package dpram_pkg;

  // Clear engine states; init_busy is simply "state == ST_CLEAR".
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dpram_state_t;

  // Address width for a given depth (depth >= 2).
  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Word must split into a whole number of byte lanes.
  function automatic bit width_ok(input int unsigned width, input int unsigned byte_w);
    return (byte_w != 0) && (width >= byte_w) && ((width % byte_w) == 0);
  endfunction

  // Only one or two output register stages are implemented.
  function automatic bit latency_ok(input int unsigned latency);
    return (latency == 1) || (latency == 2);
  endfunction

endpackage

// File: rtl/param_dp_ram_if.sv
// Bus interface of param_dp_ram: clear control, write port and read port.
interface param_dp_ram_if #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned MEM_WIDTH = 32,
  parameter int unsigned BYTE_W    = 8
);

  localparam int unsigned NB = MEM_WIDTH / BYTE_W;
  localparam int unsigned AW = dpram_pkg::addr_w(MEM_DEPTH);

  logic                 clear_req;
  logic                 init_busy;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [NB-1:0]        wr_be;
  logic [MEM_WIDTH-1:0] wr_data;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic [MEM_WIDTH-1:0] rd_data;
  logic                 rd_valid;

  // Load/store controller side.
  modport master (
    output clear_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  init_busy, rd_data, rd_valid
  );

  // RAM side.
  modport slave (
    input  clear_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output init_busy, rd_data, rd_valid
  );

endinterface

// File: rtl/dpram_rd_pipe.sv
// Read-data delay line: LATENCY register stages carrying a valid tag.
// Each data stage only loads when its incoming valid is set, so the
// output holds the last returned word between read responses.
module dpram_rd_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [LATENCY-1:0] vld_q;
  logic [WIDTH-1:0]   dat_q [LATENCY];

  // Shift valid every cycle; advance data only alongside a valid tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        dat_q[0] <= in_data;
      end
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/param_dp_ram.sv
// Parametrised simple dual-port RAM (one write port, one read port) with
// byte-lane write enables, 1- or 2-cycle read latency and a hardware
// clear engine that zeroes the array after reset or on clear_req.
// Optional feature macro: DPRAM_RDW_FWD_EN (read-during-write forwarding
// of the enabled write lanes into a same-address read).
module param_dp_ram
  import dpram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned MEM_WIDTH  = 32,
  parameter int unsigned BYTE_W     = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic           clk,
  input  logic           reset,
  param_dp_ram_if.slave  bus
);

  localparam int unsigned NB = MEM_WIDTH / BYTE_W;
  localparam int unsigned AW = addr_w(MEM_DEPTH);

  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(MEM_DEPTH);

  // Elaboration-time configuration checks.
  if (!width_ok(MEM_WIDTH, BYTE_W)) begin : g_bad_width
    $error("param_dp_ram: MEM_WIDTH must be a non-zero multiple of BYTE_W");
  end
  if (!latency_ok(RD_LATENCY)) begin : g_bad_latency
    $error("param_dp_ram: RD_LATENCY must be 1 or 2");
  end
  if (MEM_DEPTH < 2) begin : g_bad_depth
    $error("param_dp_ram: MEM_DEPTH must be at least 2");
  end

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  dpram_state_t  state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  logic                 init_busy;
  logic                 wr_ok;
  logic                 rd_ok;
  logic                 rd_in_range;
  logic [MEM_WIDTH-1:0] rd_word;

  assign init_busy     = (state_q == ST_CLEAR);
  assign bus.init_busy = init_busy;

  // Non-power-of-two depths leave addresses past the array; those writes drop.
  assign wr_ok       = bus.wr_en && !init_busy && ({1'b0, bus.wr_addr} < DEPTH_EXT);
  assign rd_ok       = bus.rd_en && !init_busy;
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_EXT);

  // Clear engine next state: walk every address once, then serve traffic.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_READY;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      ST_READY: begin
        if (bus.clear_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Clear engine state registers; reset restarts the clear from address 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Array update: clear engine owns the array while busy, else byte-lane writes.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (bus.wr_be[i]) begin
          mem[bus.wr_addr][i*BYTE_W +: BYTE_W] <= bus.wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // First read stage input: array word (zero when out of range), optionally
  // overlaid with the lanes being written to the same address this cycle.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[bus.rd_addr];
    end
`ifdef DPRAM_RDW_FWD_EN
    if (wr_ok && (bus.wr_addr == bus.rd_addr)) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (bus.wr_be[i]) begin
          rd_word[i*BYTE_W +: BYTE_W] = bus.wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
`endif
  end

  dpram_rd_pipe #(
    .WIDTH   (MEM_WIDTH),
    .LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_ok),
    .in_data   (rd_word),
    .out_valid (bus.rd_valid),
    .out_data  (bus.rd_data)
  );

endmodule
